// File: rtl/alien_hit_detector.sv
// -----------------------------------------------------------------------------
// alien_hit_detector
//
// Watches the VGA scan for a pixel where the player bullet and an alien overlap,
// then turns that scan position into the (row, column) index of the alien that
// was hit. The index is found by repeated subtraction of the alien pitch, one
// step per clock, so no divider is needed. The result is offered to the
// formation controller over a valid/ready handshake, and bullet_kill pulses on
// acceptance so the bullet can be retired. At most one hit is taken per frame.
//
// Ports
//   clk          system / pixel clock
//   rst          asynchronous reset, active high
//   scan_x/y     current VGA scan position (16 bit)
//   frame_start  one-cycle pulse at the start of each frame
//   alien_pixel  any alien graphic lit at the scan position
//   bullet_pixel player bullet graphic lit at the scan position
//   formation_x/y top-left of alien [0][0]
//   hit_valid    hit_row/hit_col valid, held until accepted
//   hit_ready    consumer accepts the hit when high together with hit_valid
//   hit_row/col  index of the hit alien
//   bullet_kill  one-cycle pulse after the hit handshake
//   busy         high whenever a resolution or report is in progress
// -----------------------------------------------------------------------------
module alien_hit_detector #(
    parameter int          NUM_ROWS        = 2,
    parameter int          NUM_COLUMNS     = 4,
    parameter logic [15:0] ALIEN_SPACING_X = 16'd40,
    parameter logic [15:0] ALIEN_SPACING_Y = 16'd40,
    localparam int         ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int         COL_W  = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1,
    // Working counters must be able to reach NUM_ROWS / NUM_COLUMNS itself,
    // which is how an out-of-formation position is recognised.
    localparam int         RCNT_W = $clog2(NUM_ROWS + 1),
    localparam int         CCNT_W = $clog2(NUM_COLUMNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      scan_x,
    input  logic [15:0]      scan_y,
    input  logic             frame_start,
    input  logic             alien_pixel,
    input  logic             bullet_pixel,
    input  logic [15:0]      formation_x,
    input  logic [15:0]      formation_y,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [ROW_W-1:0] hit_row,
    output logic [COL_W-1:0] hit_col,
    output logic             bullet_kill,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        DIV_X,
        DIV_Y,
        CHECK,
        REPORT
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       dx_q, dx_d;
    logic [15:0]       dy_q, dy_d;
    logic [CCNT_W-1:0] col_q, col_d;
    logic [RCNT_W-1:0] row_q, row_d;
    logic              frame_hit_q, frame_hit_d;
    logic [ROW_W-1:0]  hit_row_q, hit_row_d;
    logic [COL_W-1:0]  hit_col_q, hit_col_d;
    logic              bullet_kill_q, bullet_kill_d;

    logic              coincidence;
    logic              in_formation;

    // frame_start takes priority: a coincidence on the same cycle is not taken.
    assign coincidence  = alien_pixel & bullet_pixel & ~frame_hit_q & ~frame_start;
    assign in_formation = (scan_x >= formation_x) && (scan_y >= formation_y);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        col_d         = col_q;
        row_d         = row_q;
        frame_hit_d   = frame_hit_q;
        hit_row_d     = hit_row_q;
        hit_col_d     = hit_col_q;
        bullet_kill_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (coincidence && in_formation) begin
                    dx_d        = scan_x - formation_x;
                    dy_d        = scan_y - formation_y;
                    col_d       = '0;
                    row_d       = '0;
                    frame_hit_d = 1'b1;
                    state_d     = DIV_X;
                end
            end

            DIV_X: begin
                // Stopping at NUM_COLUMNS bounds latency for far-right positions.
                if (col_q == CCNT_W'(NUM_COLUMNS)) begin
                    state_d = DIV_Y;
                end else if (dx_q >= ALIEN_SPACING_X) begin
                    dx_d  = dx_q - ALIEN_SPACING_X;
                    col_d = col_q + 1'b1;
                end else begin
                    state_d = DIV_Y;
                end
            end

            DIV_Y: begin
                if (row_q == RCNT_W'(NUM_ROWS)) begin
                    state_d = CHECK;
                end else if (dy_q >= ALIEN_SPACING_Y) begin
                    dy_d  = dy_q - ALIEN_SPACING_Y;
                    row_d = row_q + 1'b1;
                end else begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if ((col_q >= CCNT_W'(NUM_COLUMNS)) || (row_q >= RCNT_W'(NUM_ROWS))) begin
                    // Scan was inside the bounding origin but past the last
                    // alien: give the frame back so a real hit can still count.
                    frame_hit_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    hit_row_d = row_q[ROW_W-1:0];
                    hit_col_d = col_q[COL_W-1:0];
                    state_d   = REPORT;
                end
            end

            REPORT: begin
                if (hit_ready) begin
                    bullet_kill_d = 1'b1;
                    state_d       = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // A new frame re-arms detection regardless of state; an in-flight
        // resolution continues untouched.
        if (frame_start) begin
            frame_hit_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            dx_q          <= '0;
            dy_q          <= '0;
            col_q         <= '0;
            row_q         <= '0;
            frame_hit_q   <= 1'b0;
            hit_row_q     <= '0;
            hit_col_q     <= '0;
            bullet_kill_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            col_q         <= col_d;
            row_q         <= row_d;
            frame_hit_q   <= frame_hit_d;
            hit_row_q     <= hit_row_d;
            hit_col_q     <= hit_col_d;
            bullet_kill_q <= bullet_kill_d;
        end
    end

    assign hit_valid   = (state_q == REPORT);
    assign busy        = (state_q != IDLE);
    assign hit_row     = hit_row_q;
    assign hit_col     = hit_col_q;
    assign bullet_kill = bullet_kill_q;

endmodule

// File: tb/tb_alien_hit_detector.sv
// -----------------------------------------------------------------------------
// tb_alien_hit_detector
//
// Directed bench for alien_hit_detector with default parameters (2 rows,
// 4 columns, 40 pixel pitch) and the formation parked at (50,50).
// Expected latencies are counted in clock edges after the capture edge:
// a hit resolving to column c, row r shows hit_valid c+r+3 edges later.
// -----------------------------------------------------------------------------
module tb_alien_hit_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] scan_x;
    logic [15:0] scan_y;
    logic        frame_start;
    logic        alien_pixel;
    logic        bullet_pixel;
    logic [15:0] formation_x;
    logic [15:0] formation_y;
    logic        hit_valid;
    logic        hit_ready;
    logic [0:0]  hit_row;
    logic [1:0]  hit_col;
    logic        bullet_kill;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alien_hit_detector dut (
        .clk          (clk),
        .rst          (rst),
        .scan_x       (scan_x),
        .scan_y       (scan_y),
        .frame_start  (frame_start),
        .alien_pixel  (alien_pixel),
        .bullet_pixel (bullet_pixel),
        .formation_x  (formation_x),
        .formation_y  (formation_y),
        .hit_valid    (hit_valid),
        .hit_ready    (hit_ready),
        .hit_row      (hit_row),
        .hit_col      (hit_col),
        .bullet_kill  (bullet_kill),
        .busy         (busy)
    );

    // Present a one-cycle coincidence; returns 1 time unit after the capture edge.
    task automatic drive_hit(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        scan_x       = x;
        scan_y       = y;
        alien_pixel  = 1'b1;
        bullet_pixel = 1'b1;
        @(posedge clk);
        #1;
        alien_pixel  = 1'b0;
        bullet_pixel = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Edges until hit_valid is seen (bounded to 20); -1 if it never appears.
    task automatic wait_valid(output int lat);
        int k;
        lat = -1;
        k   = 0;
        while (lat < 0 && k < 20) begin
            k++;
            @(posedge clk);
            #1;
            if (hit_valid) lat = k;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        scan_x       = '0;
        scan_y       = '0;
        frame_start  = 1'b0;
        alien_pixel  = 1'b0;
        bullet_pixel = 1'b0;
        formation_x  = 16'd50;
        formation_y  = 16'd50;
        hit_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({hit_valid, bullet_kill, busy, hit_row, hit_col} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b k=%b b=%b r=%0d c=%0d want all 0",
                     hit_valid, bullet_kill, busy, hit_row, hit_col);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_hit();
        int lat;
        hit_ready = 1'b1;
        drive_hit(16'd135, 16'd95);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        wait_valid(lat);
        total++;
        if (lat != 6) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 6", lat);
        end
        total++;
        if (hit_row !== 1'b1 || hit_col !== 2'd2) begin
            bad++;
            $display("FAIL basic_index: got row=%0d col=%0d want row=1 col=2", hit_row, hit_col);
        end
        @(posedge clk);
        #1;
        total++;
        if (bullet_kill !== 1'b1 || hit_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_kill: got kill=%b valid=%b want kill=1 valid=0",
                     bullet_kill, hit_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (bullet_kill !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_kill_end: got kill=%b busy=%b want 0 0", bullet_kill, busy);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        pulse_frame();
        hit_ready = 1'b0;
        drive_hit(16'd135, 16'd95);
        wait_valid(lat);
        total++;
        if (lat != 6) begin
            bad++;
            $display("FAIL bp_latency: got %0d want 6", lat);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (hit_valid !== 1'b1 || hit_row !== 1'b1 || hit_col !== 2'd2 || bullet_kill !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%0d c=%0d k=%b want v=1 r=1 c=2 k=0",
                         i, hit_valid, hit_row, hit_col, bullet_kill);
            end
        end
        hit_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bullet_kill !== 1'b1 || hit_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_kill: got kill=%b valid=%b want kill=1 valid=0",
                     bullet_kill, hit_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (bullet_kill !== 1'b0) begin
            bad++;
            $display("FAIL bp_kill_end: got %b want 0", bullet_kill);
        end
    endtask

    task automatic test_same_frame();
        int lat;
        drive_hit(16'd55, 16'd55);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL same_frame_busy: got %b want 0", busy);
        end
        wait_valid(lat);
        total++;
        if (lat != -1) begin
            bad++;
            $display("FAIL same_frame_ignored: got latency %0d want no hit", lat);
        end
        pulse_frame();
        drive_hit(16'd55, 16'd55);
        wait_valid(lat);
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL new_frame_latency: got %0d want 3", lat);
        end
        total++;
        if (hit_row !== 1'b0 || hit_col !== 2'd0) begin
            bad++;
            $display("FAIL new_frame_index: got row=%0d col=%0d want row=0 col=0", hit_row, hit_col);
        end
        @(posedge clk);
        #1;
        total++;
        if (bullet_kill !== 1'b1) begin
            bad++;
            $display("FAIL new_frame_kill: got %b want 1", bullet_kill);
        end
    endtask

    task automatic test_out_of_range();
        int lat;
        pulse_frame();
        drive_hit(16'd210, 16'd60);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL oor_busy: got %b want 1", busy);
        end
        wait_valid(lat);
        total++;
        if (lat != -1) begin
            bad++;
            $display("FAIL oor_no_hit: got latency %0d want no hit", lat);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL oor_busy_drop: got %b want 0", busy);
        end
        drive_hit(16'd60, 16'd60);
        wait_valid(lat);
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL oor_rearm_latency: got %0d want 3", lat);
        end
        total++;
        if (hit_row !== 1'b0 || hit_col !== 2'd0) begin
            bad++;
            $display("FAIL oor_rearm_index: got row=%0d col=%0d want row=0 col=0", hit_row, hit_col);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_frame_start_collision();
        int lat;
        // frame_hit is set here; frame_start and a coincidence on one edge.
        @(negedge clk);
        scan_x       = 16'd135;
        scan_y       = 16'd95;
        frame_start  = 1'b1;
        alien_pixel  = 1'b1;
        bullet_pixel = 1'b1;
        @(posedge clk);
        #1;
        frame_start  = 1'b0;
        alien_pixel  = 1'b0;
        bullet_pixel = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL collide_no_capture: got busy=%b want 0", busy);
        end
        // Flag now clear: next coincidence is taken; frame_start in flight must not abort it.
        drive_hit(16'd60, 16'd60);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        wait_valid(lat);
        total++;
        if (lat != 2) begin
            bad++;
            $display("FAIL collide_inflight_latency: got %0d want 2", lat);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_below_formation();
        int lat;
        pulse_frame();
        drive_hit(16'd40, 16'd60);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL below_busy: got %b want 0", busy);
        end
        // Flag left untouched by the discard, so this one is taken.
        drive_hit(16'd135, 16'd95);
        wait_valid(lat);
        total++;
        if (lat != 6 || hit_row !== 1'b1 || hit_col !== 2'd2) begin
            bad++;
            $display("FAIL below_then_hit: got lat=%0d row=%0d col=%0d want lat=6 row=1 col=2",
                     lat, hit_row, hit_col);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        pulse_frame();
        drive_hit(16'd135, 16'd95);
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_busy_before: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({hit_valid, bullet_kill, busy, hit_row, hit_col} !== 6'b0) begin
            bad++;
            $display("FAIL midrst_outputs: got v=%b k=%b b=%b r=%0d c=%0d want all 0",
                     hit_valid, bullet_kill, busy, hit_row, hit_col);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_valid(lat);
        total++;
        if (lat != -1) begin
            bad++;
            $display("FAIL midrst_no_hit: got latency %0d want no hit", lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_backpressure();
        test_same_frame();
        test_out_of_range();
        test_frame_start_collision();
        test_below_formation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
